// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - geometry, colour and state definitions shared by the pong core
package pong_pkg;

    localparam logic [9:0] SCREEN_W     = 10'd640;
    localparam logic [9:0] SCREEN_H     = 10'd480;
    localparam logic [9:0] PADDLE_W     = 10'd8;
    localparam logic [9:0] PADDLE_H     = 10'd64;
    localparam logic [9:0] BALL_SIZE    = 10'd8;
    localparam logic [9:0] PADDLE_SPEED = 10'd4;
    localparam logic [9:0] BALL_SPEED   = 10'd2;
    localparam logic [5:0] SERVE_FRAMES = 6'd60;
    localparam logic [3:0] WIN_SCORE    = 4'd9;

    localparam logic [9:0] PADDLE_Y_MAX = SCREEN_H - PADDLE_H;
    localparam logic [9:0] PADDLE_Y0    = 10'd208;
    localparam logic [9:0] L_PAD_X      = 10'd16;
    localparam logic [9:0] R_PAD_X      = 10'd616;
    localparam logic [9:0] BALL_X0      = 10'd316;
    localparam logic [9:0] BALL_Y0      = 10'd236;
    localparam logic [9:0] CENTRE_X0    = 10'd318;
    localparam logic [9:0] CENTRE_X1    = 10'd321;

    localparam logic [23:0] RGB_BLACK  = 24'h000000;
    localparam logic [23:0] RGB_YELLOW = 24'hFFFF00;
    localparam logic [23:0] RGB_WHITE  = 24'hFFFFFF;
    localparam logic [23:0] RGB_GREY   = 24'h808080;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SERVE,
        ST_PLAY,
        ST_POINT,
        ST_GAMEOVER
    } state_t;

    // Both or neither key held leaves the paddle where it is.
    function automatic logic [9:0] paddle_step(input logic [9:0] y, input logic up, input logic dn);
        logic [9:0] ny;
        ny = y;
        if (up && !dn) begin
            ny = (y < PADDLE_SPEED) ? 10'd0 : y - PADDLE_SPEED;
        end else if (dn && !up) begin
            ny = (y > PADDLE_Y_MAX - PADDLE_SPEED) ? PADDLE_Y_MAX : y + PADDLE_SPEED;
        end
        return ny;
    endfunction

endpackage

// File: rtl/pong_draw.sv
// rtl/pong_draw.sv - registered pixel colour generator for ball, paddles and centre line
module pong_draw
    import pong_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [9:0]  px,
    input  logic [9:0]  py,
    input  logic [9:0]  bx,
    input  logic [9:0]  by,
    input  logic [9:0]  lpy,
    input  logic [9:0]  rpy,
    output logic [23:0] pixel
);

    logic        visible;
    logic        in_ball;
    logic        in_lpad;
    logic        in_rpad;
    logic        in_centre;
    logic [23:0] colour;

    always_comb begin
        visible   = (px < SCREEN_W) && (py < SCREEN_H);
        in_ball   = (px >= bx) && (px < bx + BALL_SIZE) && (py >= by) && (py < by + BALL_SIZE);
        in_lpad   = (px >= L_PAD_X) && (px < L_PAD_X + PADDLE_W) && (py >= lpy) && (py < lpy + PADDLE_H);
        in_rpad   = (px >= R_PAD_X) && (px < R_PAD_X + PADDLE_W) && (py >= rpy) && (py < rpy + PADDLE_H);
        in_centre = (px >= CENTRE_X0) && (px <= CENTRE_X1) && !py[4];

        colour = RGB_BLACK;
        if (!visible) begin
            colour = RGB_BLACK;
        end else if (in_ball) begin
            colour = RGB_YELLOW;
        end else if (in_lpad || in_rpad) begin
            colour = RGB_WHITE;
        end else if (in_centre) begin
            colour = RGB_GREY;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pixel <= RGB_BLACK;
        end else begin
            pixel <= colour;
        end
    end

endmodule

// File: rtl/pong_game_core.sv
// rtl/pong_game_core.sv - per-frame pong game state machine feeding the pixel generator
module pong_game_core
    import pong_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [9:0]  px,
    input  logic [9:0]  py,
    input  logic        key_up_l,
    input  logic        key_dn_l,
    input  logic        key_up_r,
    input  logic        key_dn_r,
    input  logic        start,
    output logic [23:0] pixel,
    output logic [3:0]  score_l,
    output logic [3:0]  score_r,
    output logic        game_over
);

    // Key order: {start, up_l, dn_l, up_r, dn_r}
    logic [4:0] keys_meta, keys_sync;
    logic       start_prev;
    logic [9:0] py_q;
    logic       start_edge, frame_tick;

    state_t     state, state_nxt;
    logic [5:0] cnt, cnt_nxt;
    logic [9:0] lpy, lpy_nxt, rpy, rpy_nxt;
    logic [9:0] bx, bx_nxt, by, by_nxt;
    logic       dx_neg, dx_neg_nxt, dy_neg, dy_neg_nxt;
    logic       serve_neg, serve_neg_nxt;
    logic [3:0] score_l_nxt, score_r_nxt;
    logic       serve_load, serve_dir;
    logic       l_overlap, r_overlap;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            keys_meta  <= '0;
            keys_sync  <= '0;
            start_prev <= 1'b0;
            py_q       <= '0;
        end else begin
            keys_meta  <= {start, key_up_l, key_dn_l, key_up_r, key_dn_r};
            keys_sync  <= keys_meta;
            start_prev <= keys_sync[4];
            py_q       <= py;
        end
    end

    assign start_edge = keys_sync[4] && !start_prev;
    assign frame_tick = (py_q != SCREEN_H) && (py == SCREEN_H);
    assign l_overlap  = (by + BALL_SIZE > lpy) && (by < lpy + PADDLE_H);
    assign r_overlap  = (by + BALL_SIZE > rpy) && (by < rpy + PADDLE_H);
    assign game_over  = (state == ST_GAMEOVER);

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        lpy_nxt       = lpy;
        rpy_nxt       = rpy;
        bx_nxt        = bx;
        by_nxt        = by;
        dx_neg_nxt    = dx_neg;
        dy_neg_nxt    = dy_neg;
        serve_neg_nxt = serve_neg;
        score_l_nxt   = score_l;
        score_r_nxt   = score_r;
        serve_load    = 1'b0;
        serve_dir     = 1'b0;

        if (frame_tick && state != ST_GAMEOVER) begin
            lpy_nxt = paddle_step(lpy, keys_sync[3], keys_sync[2]);
            rpy_nxt = paddle_step(rpy, keys_sync[1], keys_sync[0]);
        end

        if (start_edge && (state == ST_IDLE || state == ST_GAMEOVER)) begin
            score_l_nxt   = '0;
            score_r_nxt   = '0;
            serve_neg_nxt = 1'b0;
            serve_load    = 1'b1;
        end else if (frame_tick) begin
            case (state)
                ST_SERVE: begin
                    if (cnt == SERVE_FRAMES - 6'd1) begin
                        state_nxt = ST_PLAY;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 6'd1;
                    end
                end
                ST_POINT: begin
                    if (cnt == SERVE_FRAMES - 6'd1) begin
                        cnt_nxt = '0;
                        if (score_l == WIN_SCORE || score_r == WIN_SCORE) begin
                            state_nxt = ST_GAMEOVER;
                        end else begin
                            serve_load = 1'b1;
                            serve_dir  = serve_neg;
                        end
                    end else begin
                        cnt_nxt = cnt + 6'd1;
                    end
                end
                ST_PLAY: begin
                    if (dy_neg && by < BALL_SPEED) begin
                        by_nxt     = '0;
                        dy_neg_nxt = 1'b0;
                    end else if (!dy_neg && by > SCREEN_H - BALL_SIZE - BALL_SPEED) begin
                        by_nxt     = SCREEN_H - BALL_SIZE;
                        dy_neg_nxt = 1'b1;
                    end else begin
                        by_nxt = dy_neg ? by - BALL_SPEED : by + BALL_SPEED;
                    end

                    // Paddle faces: left at x=24, right at x=616 (ball left edge 608).
                    if (dx_neg) begin
                        if (bx <= L_PAD_X + PADDLE_W + BALL_SPEED && l_overlap) begin
                            bx_nxt     = L_PAD_X + PADDLE_W;
                            dx_neg_nxt = 1'b0;
                        end else if (bx < BALL_SPEED) begin
                            score_r_nxt   = (score_r < WIN_SCORE) ? score_r + 4'd1 : score_r;
                            serve_neg_nxt = 1'b1;
                            state_nxt     = ST_POINT;
                            cnt_nxt       = '0;
                        end else begin
                            bx_nxt = bx - BALL_SPEED;
                        end
                    end else begin
                        if (bx + BALL_SIZE + BALL_SPEED >= R_PAD_X && r_overlap) begin
                            bx_nxt     = R_PAD_X - BALL_SIZE;
                            dx_neg_nxt = 1'b1;
                        end else if (bx + BALL_SIZE + BALL_SPEED >= SCREEN_W) begin
                            score_l_nxt   = (score_l < WIN_SCORE) ? score_l + 4'd1 : score_l;
                            serve_neg_nxt = 1'b0;
                            state_nxt     = ST_POINT;
                            cnt_nxt       = '0;
                        end else begin
                            bx_nxt = bx + BALL_SPEED;
                        end
                    end
                end
                default: ;
            endcase
        end

        if (serve_load) begin
            state_nxt  = ST_SERVE;
            cnt_nxt    = '0;
            bx_nxt     = BALL_X0;
            by_nxt     = BALL_Y0;
            dy_neg_nxt = 1'b0;
            dx_neg_nxt = serve_dir;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            lpy       <= PADDLE_Y0;
            rpy       <= PADDLE_Y0;
            bx        <= BALL_X0;
            by        <= BALL_Y0;
            dx_neg    <= 1'b0;
            dy_neg    <= 1'b0;
            serve_neg <= 1'b0;
            score_l   <= '0;
            score_r   <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            lpy       <= lpy_nxt;
            rpy       <= rpy_nxt;
            bx        <= bx_nxt;
            by        <= by_nxt;
            dx_neg    <= dx_neg_nxt;
            dy_neg    <= dy_neg_nxt;
            serve_neg <= serve_neg_nxt;
            score_l   <= score_l_nxt;
            score_r   <= score_r_nxt;
        end
    end

    pong_draw u_draw (
        .clk     (clk),
        .reset_n (reset_n),
        .px      (px),
        .py      (py),
        .bx      (bx),
        .by      (by),
        .lpy     (lpy),
        .rpy     (rpy),
        .pixel   (pixel)
    );

endmodule

// File: tb/tb_pong_game_core.sv
// tb/tb_pong_game_core.sv - directed self-checking bench for pong_game_core
module tb_pong_game_core;

    localparam logic [23:0] YEL = 24'hFFFF00;
    localparam logic [23:0] WHT = 24'hFFFFFF;
    localparam logic [23:0] GRY = 24'h808080;
    localparam logic [23:0] BLK = 24'h000000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  px = '0;
    logic [9:0]  py = '0;
    logic        key_up_l = 1'b0, key_dn_l = 1'b0, key_up_r = 1'b0, key_dn_r = 1'b0;
    logic        start = 1'b0;
    logic [23:0] pixel;
    logic [3:0]  score_l, score_r;
    logic        game_over;

    int          checks = 0;
    int          errors = 0;
    logic [23:0] c;

    pong_game_core dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .px        (px),
        .py        (py),
        .key_up_l  (key_up_l),
        .key_dn_l  (key_dn_l),
        .key_up_r  (key_up_r),
        .key_dn_r  (key_dn_r),
        .start     (start),
        .pixel     (pixel),
        .score_l   (score_l),
        .score_r   (score_r),
        .game_over (game_over)
    );

    always #10 clk = ~clk;

    task automatic probe(input logic [9:0] x, input logic [9:0] y, output logic [23:0] col);
        @(negedge clk);
        px = x;
        py = y;
        @(negedge clk);
        col = pixel;
    endtask

    task automatic tick();
        @(negedge clk);
        py = 10'd479;
        @(negedge clk);
        py = 10'd480;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_keys(input logic ul, input logic dl, input logic ur, input logic dr);
        key_up_l = ul;
        key_dn_l = dl;
        key_up_r = ur;
        key_dn_r = dr;
        repeat (3) @(negedge clk);
    endtask

    task automatic press_start();
        start = 1'b1;
        repeat (4) @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (pixel !== BLK) begin errors++; $display("FAIL reset_pixel: got %h expected %h", pixel, BLK); end
        checks++; if (score_l !== 4'd0 || score_r !== 4'd0) begin errors++; $display("FAIL reset_scores: got %0d/%0d expected 0/0", score_l, score_r); end
        checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over: got %b expected 0", game_over); end
        reset_n = 1'b1;
        @(negedge clk);
        probe(320, 240, c); checks++; if (c !== YEL) begin errors++; $display("FAIL reset_ball: got %h expected %h", c, YEL); end
        probe(20, 220, c);  checks++; if (c !== WHT) begin errors++; $display("FAIL reset_lpad: got %h expected %h", c, WHT); end
        probe(620, 220, c); checks++; if (c !== WHT) begin errors++; $display("FAIL reset_rpad: got %h expected %h", c, WHT); end
        probe(319, 0, c);   checks++; if (c !== GRY) begin errors++; $display("FAIL centre_on: got %h expected %h", c, GRY); end
        probe(319, 16, c);  checks++; if (c !== BLK) begin errors++; $display("FAIL centre_gap: got %h expected %h", c, BLK); end
    endtask

    task automatic test_frame_tick();
        set_keys(0, 1, 0, 0);
        tick();
        probe(20, 211, c); checks++; if (c !== BLK) begin errors++; $display("FAIL tick_once_above: got %h expected %h", c, BLK); end
        probe(20, 212, c); checks++; if (c !== WHT) begin errors++; $display("FAIL tick_once_top: got %h expected %h", c, WHT); end
        probe(20, 276, c); checks++; if (c !== BLK) begin errors++; $display("FAIL tick_once_below: got %h expected %h", c, BLK); end
        set_keys(1, 1, 0, 0);
        tick();
        probe(20, 212, c); checks++; if (c !== WHT) begin errors++; $display("FAIL both_keys_hold: got %h expected %h", c, WHT); end
        probe(20, 211, c); checks++; if (c !== BLK) begin errors++; $display("FAIL both_keys_above: got %h expected %h", c, BLK); end
        set_keys(0, 0, 0, 0);
    endtask

    task automatic test_paddle_clamp();
        set_keys(1, 0, 0, 0);
        ticks(60);
        probe(20, 0, c);  checks++; if (c !== WHT) begin errors++; $display("FAIL clamp_top: got %h expected %h", c, WHT); end
        probe(20, 64, c); checks++; if (c !== BLK) begin errors++; $display("FAIL clamp_bottom_edge: got %h expected %h", c, BLK); end
        probe(620, 208, c); checks++; if (c !== WHT) begin errors++; $display("FAIL rpad_untouched: got %h expected %h", c, WHT); end
        set_keys(0, 0, 0, 0);
    endtask

    task automatic test_serve_play();
        press_start();
        ticks(60);
        probe(316, 236, c); checks++; if (c !== YEL) begin errors++; $display("FAIL serve_hold: got %h expected %h", c, YEL); end
        probe(315, 236, c); checks++; if (c !== BLK) begin errors++; $display("FAIL serve_hold_left: got %h expected %h", c, BLK); end
        tick();
        probe(318, 238, c); checks++; if (c !== YEL) begin errors++; $display("FAIL first_move: got %h expected %h", c, YEL); end
        probe(317, 238, c); checks++; if (c !== BLK) begin errors++; $display("FAIL first_move_left: got %h expected %h", c, BLK); end
        probe(326, 245, c); checks++; if (c !== BLK) begin errors++; $display("FAIL first_move_right: got %h expected %h", c, BLK); end
    endtask

    task automatic test_right_bounce();
        set_keys(0, 0, 0, 1);
        ticks(144);
        probe(606, 420, c); checks++; if (c !== YEL) begin errors++; $display("FAIL pre_rbounce: got %h expected %h", c, YEL); end
        tick();
        probe(608, 418, c); checks++; if (c !== YEL) begin errors++; $display("FAIL rbounce: got %h expected %h", c, YEL); end
        probe(607, 418, c); checks++; if (c !== BLK) begin errors++; $display("FAIL rbounce_left: got %h expected %h", c, BLK); end
        probe(620, 479, c); checks++; if (c !== WHT) begin errors++; $display("FAIL rpad_clamp_low: got %h expected %h", c, WHT); end
        probe(620, 415, c); checks++; if (c !== BLK) begin errors++; $display("FAIL rpad_clamp_edge: got %h expected %h", c, BLK); end
        set_keys(0, 0, 0, 0);
    endtask

    task automatic test_top_bounce();
        ticks(210);
        probe(188, 0, c); checks++; if (c !== YEL) begin errors++; $display("FAIL top_clamp: got %h expected %h", c, YEL); end
        probe(187, 0, c); checks++; if (c !== BLK) begin errors++; $display("FAIL top_clamp_left: got %h expected %h", c, BLK); end
        tick();
        probe(186, 2, c); checks++; if (c !== YEL) begin errors++; $display("FAIL top_bounce: got %h expected %h", c, YEL); end
        probe(186, 1, c); checks++; if (c !== BLK) begin errors++; $display("FAIL top_bounce_above: got %h expected %h", c, BLK); end
    endtask

    task automatic test_left_miss();
        ticks(93);
        checks++; if (score_r !== 4'd0) begin errors++; $display("FAIL pre_left_miss: got %0d expected 0", score_r); end
        tick();
        checks++; if (score_r !== 4'd1 || score_l !== 4'd0) begin errors++; $display("FAIL left_miss: got %0d/%0d expected 0/1", score_l, score_r); end
        set_keys(0, 1, 0, 0);
        ticks(60);
        probe(316, 236, c); checks++; if (c !== YEL) begin errors++; $display("FAIL reserve_pos: got %h expected %h", c, YEL); end
        ticks(61);
        probe(321, 238, c); checks++; if (c !== YEL) begin errors++; $display("FAIL serve_dx_neg: got %h expected %h", c, YEL); end
        probe(322, 238, c); checks++; if (c !== BLK) begin errors++; $display("FAIL serve_dx_neg_right: got %h expected %h", c, BLK); end
        set_keys(0, 0, 0, 0);
    endtask

    task automatic test_left_bounce();
        ticks(144);
        probe(26, 420, c); checks++; if (c !== YEL) begin errors++; $display("FAIL pre_lbounce: got %h expected %h", c, YEL); end
        tick();
        probe(24, 418, c); checks++; if (c !== YEL) begin errors++; $display("FAIL lbounce: got %h expected %h", c, YEL); end
        probe(23, 418, c); checks++; if (c !== WHT) begin errors++; $display("FAIL lbounce_paddle: got %h expected %h", c, WHT); end
        probe(32, 418, c); checks++; if (c !== BLK) begin errors++; $display("FAIL lbounce_right: got %h expected %h", c, BLK); end
        ticks(303);
        checks++; if (score_l !== 4'd0) begin errors++; $display("FAIL pre_right_miss: got %0d expected 0", score_l); end
        tick();
        checks++; if (score_l !== 4'd1 || score_r !== 4'd1) begin errors++; $display("FAIL right_miss: got %0d/%0d expected 1/1", score_l, score_r); end
    endtask

    task automatic test_game_over();
        set_keys(0, 0, 1, 0);
        for (int r = 2; r <= 9; r++) begin
            ticks(277);
            checks++; if (score_l !== 4'(r - 1)) begin errors++; $display("FAIL round_%0d_pre: got %0d expected %0d", r, score_l, r - 1); end
            tick();
            checks++; if (score_l !== 4'(r)) begin errors++; $display("FAIL round_%0d_score: got %0d expected %0d", r, score_l, r); end
        end
        set_keys(0, 0, 0, 0);
        ticks(59);
        checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL point_before_over: got %b expected 0", game_over); end
        tick();
        checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL game_over: got %b expected 1", game_over); end
        checks++; if (score_r !== 4'd1) begin errors++; $display("FAIL loser_score: got %0d expected 1", score_r); end
        set_keys(1, 0, 0, 0);
        tick();
        probe(20, 416, c); checks++; if (c !== WHT) begin errors++; $display("FAIL gameover_freeze: got %h expected %h", c, WHT); end
        probe(20, 412, c); checks++; if (c !== BLK) begin errors++; $display("FAIL gameover_freeze_above: got %h expected %h", c, BLK); end
        set_keys(0, 0, 0, 0);
    endtask

    task automatic test_restart();
        press_start();
        checks++; if (score_l !== 4'd0 || score_r !== 4'd0) begin errors++; $display("FAIL restart_scores: got %0d/%0d expected 0/0", score_l, score_r); end
        checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL restart_game_over: got %b expected 0", game_over); end
        probe(316, 236, c); checks++; if (c !== YEL) begin errors++; $display("FAIL restart_ball: got %h expected %h", c, YEL); end
        probe(700, 236, c); checks++; if (c !== BLK) begin errors++; $display("FAIL offscreen_x: got %h expected %h", c, BLK); end
        probe(321, 0, c);   checks++; if (c !== GRY) begin errors++; $display("FAIL centre_edge: got %h expected %h", c, GRY); end
        probe(322, 0, c);   checks++; if (c !== BLK) begin errors++; $display("FAIL centre_past: got %h expected %h", c, BLK); end
    endtask

    task automatic test_mid_reset();
        probe(316, 236, c);
        reset_n = 1'b0;
        #1;
        checks++; if (pixel !== BLK) begin errors++; $display("FAIL async_reset_pixel: got %h expected %h", pixel, BLK); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        probe(20, 208, c); checks++; if (c !== WHT) begin errors++; $display("FAIL reset_lpad_home: got %h expected %h", c, WHT); end
        probe(20, 207, c); checks++; if (c !== BLK) begin errors++; $display("FAIL reset_lpad_above: got %h expected %h", c, BLK); end
        set_keys(0, 1, 0, 0);
        tick();
        probe(20, 212, c); checks++; if (c !== WHT) begin errors++; $display("FAIL post_reset_tick: got %h expected %h", c, WHT); end
        probe(20, 211, c); checks++; if (c !== BLK) begin errors++; $display("FAIL post_reset_tick_above: got %h expected %h", c, BLK); end
        set_keys(0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_frame_tick();
        test_paddle_clamp();
        test_serve_play();
        test_right_bounce();
        test_top_bounce();
        test_left_miss();
        test_left_bounce();
        test_game_over();
        test_restart();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pong_game_core.md
# pong_game_core

Game-state and pixel-generation stage for the DE2 pong design; sits directly upstream of the VGA datapath. Consumes the datapath's current scan coordinates (px, py) and returns the 24-bit RGB colour for that pixel one clock later. Once per frame it advances paddle positions from player keys and moves the ball (wall/paddle bounce, miss detection, scoring) under a serve/play/point/game-over state machine.

## Interface
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in lines
- PADDLE_W, 8, paddle width
- PADDLE_H, 64, paddle height
- BALL_SIZE, 8, ball edge length (square)
- PADDLE_SPEED, 4, paddle step per frame
- BALL_SPEED, 2, ball step per axis per frame
- SERVE_FRAMES, 60, frames held in SERVE/POINT before release
- WIN_SCORE, 9, score that ends the game
- clk  in  1  50 MHz system clock, same clock as the VGA datapath
- reset_n  in  1  asynchronous, active-low reset
- px  in  10  current scan column from VGA datapath (0..799)
- py  in  10  current scan line from VGA datapath (0..524)
- key_up_l, key_dn_l, key_up_r, key_dn_r  in  1 each  paddle keys, active-high, asynchronous
- start  in  1  start/restart key, active-high, asynchronous
- pixel  out  24  {R,G,B} colour for (px,py), registered
- score_l, score_r  out  4 each  player scores
- game_over  out  1  high while in GAMEOVER

## Operation
- All key inputs pass through two-flop synchronisers; start is used as a rising-edge pulse.
- frame_tick: one-clk pulse when py becomes SCREEN_H (registered py_q != SCREEN_H, py == SCREEN_H). All game state updates only on frame_tick.
- Geometry: left paddle x 16..23, right paddle x 616..623; paddle y = top edge, clamped 0..SCREEN_H-PADDLE_H (416). Ball (bx,by) top-left, velocity dx,dy each ±BALL_SPEED.
- Paddles: up key decrements y by PADDLE_SPEED, down increments; both or neither pressed -> hold; clamp at limits. Paddles move in every state except GAMEOVER.
- States: IDLE -> (start edge) SERVE -> (SERVE_FRAMES ticks) PLAY -> (miss) POINT -> (SERVE_FRAMES ticks) SERVE, or GAMEOVER if scorer reached WIN_SCORE. GAMEOVER -> (start edge) scores cleared, SERVE.
- SERVE entry: ball at (316,236), dy = +BALL_SPEED, dx toward the player who conceded the last point (+ after reset/restart).
- PLAY ball update per tick, evaluated in order:
  - top: dy<0 and by < BALL_SPEED -> by=0, dy=+; bottom: dy>0 and by+BALL_SIZE+BALL_SPEED > 480 -> by=472, dy=-; else by+=dy.
  - left: dx<0 and bx+dx <= 24 and vertical overlap (by+8 > lpy and by < lpy+64) -> bx=24, dx=+; else if bx < BALL_SPEED -> score_r+1, POINT.
  - right: dx>0 and bx+8+dx >= 616 with overlap -> bx=608, dx=-; else if bx+8+dx >= 640 -> score_l+1, POINT.
  - otherwise bx+=dx.
- Scores saturate at WIN_SCORE; simultaneous corner hit is impossible (one horizontal side per tick).
- Pixel colour, priority high to low: outside visible area (px>=640 or py>=480) 000000; ball FFFF00; paddles FFFFFF; centre line (px 318..321, py[4]==0) 808080; background 000000.

## Timing
- pixel registered: value for (px,py) sampled at edge N appears at edge N+1; px holds 2 clk, so output is stable for ≥1 clk per pixel.
- Game state changes one clk after frame_tick, during vertical blanking; no tearing.
- Reset values: pixel 0, scores 0, game_over 0, state IDLE, paddles y=208, ball (316,236), dx=dy=+BALL_SPEED, frame counter 0.
- reset_n asserted mid-frame: all state cleared immediately; first frame_tick after release counts normally.
- start edge in SERVE/PLAY/POINT: ignored.

## Structure
- Package pong_pkg: geometry constants, colour constants, state enum (IDLE, SERVE, PLAY, POINT, GAMEOVER).
- Sub-module pong_draw: registered pixel-colour generator taking px, py, ball and paddle positions.

## Test plan
- Reset, hold keys low, drive py 479->480 -> exactly one frame_tick; state IDLE, pixel at (320,240) = FFFF00 (ball), at (20,220) = FFFFFF.
- Start pulse, 60 ticks -> PLAY; next tick ball at (318,238).
- Hold key_up_l for 60 ticks -> left paddle y clamps at 0, never negative; both keys high -> y unchanged.
- Ball at by=1, dy=-2 -> by=0, dy=+2; ball at bx=26, dx=-2, lpy covering by -> bx=24, dx=+2.
- Left paddle away, ball reaches bx<2 -> score_r=1, POINT, after 60 ticks SERVE with dx=-2.
- score_l=8, right miss -> score_l=9, game_over=1; start edge -> scores 0, SERVE; px=700 -> pixel 000000.
